// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// the scan phase type and the segment patterns {g,f,e,d,c,b,a}, active-high.
package seg7_scan_driver_pkg;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // All segments dark.
  localparam logic [6:0] DIG_OFF = 7'h00;

endpackage

// File: rtl/hex2seg7.sv
// Combinational hex nibble to 7-segment pattern decoder, active-high.
// Shared by the scan driver and the debug display.
module hex2seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Look up the segment pattern for the nibble.
  always_comb begin
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver. The processor writes a shadow copy at any
// time; the shadow is copied to the display registers only at frame boundaries,
// so one frame never mixes old and new digits. Each digit slot begins with a
// blanking gap so the digit enables never overlap.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100_000,
  parameter int BLANK_CYCLES   = 2_000,
  parameter int CNT_BITS       = 17,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  output logic                    wr_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int                  IDX_W     = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(REFRESH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_DRIVE = CNT_BITS'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic                INV       = (ACTIVE_LOW != 1'b0);
  // Phase entered at the start of every slot (no gap at all if BLANK_CYCLES is 0).
  localparam phase_t              PH_START  = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  logic [CNT_BITS-1:0]   cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [4*NUM_DIGITS-1:0] display_data;
  logic [NUM_DIGITS-1:0]   display_dp;
  logic [NUM_DIGITS-1:0]   display_blank;

  phase_t                phase;
  phase_t                phase_next;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_code;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot counter and digit index; idx advances each time the slot counter wraps.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge values of the others, independent of block order.
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers capture every write strobe; wr_ack echoes it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      wr_ack       <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en) begin
        shadow_data  <= wr_data;
        shadow_dp    <= wr_dp;
        shadow_blank <= wr_blank;
      end
    end
  end

  // Display registers load from the shadow only at a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_data  <= '0;
      display_dp    <= '0;
      display_blank <= '0;
    end else if (frame_end) begin
      // NOTE: a write sampled on this same edge has not reached the shadow yet,
      // so the display takes the pre-write value and the new one waits a frame.
      display_data  <= shadow_data;
      display_dp    <= shadow_dp;
      display_blank <= shadow_blank;
    end
  end

  // Phase register: tracks whether the current cnt lies in the blanking gap.
  always_ff @(posedge clk) begin
    if (reset) phase <= PH_START;
    else       phase <= phase_next;
  end

  assign cur_nib = display_data[{idx, 2'b00} +: 4];

  hex2seg7 u_hex2seg7 (
    .nib (cur_nib),
    .seg (cur_code)
  );

  // Next phase and the unregistered digit/segment selection for the current cnt/idx.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    phase_next = phase;
    an_d       = '0;
    seg_d      = DIG_OFF;
    dp_d       = 1'b0;

    unique case (phase)
      PH_BLANK: begin
        if (slot_end)                     phase_next = PH_START;
        else if (cnt + 1'b1 == CNT_DRIVE) phase_next = PH_DRIVE;
      end
      PH_DRIVE: begin
        if (slot_end) phase_next = PH_START;
        an_d[idx] = 1'b1;
        if (!display_blank[idx]) begin
          seg_d = cur_code;
          dp_d  = display_dp[idx];
        end
      end
      default: phase_next = PH_START;
    endcase
  end

  // Output register with the board polarity applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {NUM_DIGITS{INV}};
      seg <= {7{INV}};
      dp  <= INV;
    end else begin
      an  <= an_d ^ {NUM_DIGITS{INV}};
      seg <= seg_d ^ {7{INV}};
      dp  <= dp_d ^ INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high and an active-low instance share
// one stimulus. A frame-arithmetic model predicts the outputs on every cycle,
// and directed checks pin individual digits to hand-computed segment codes.
module tb_seg7_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int C = 3;
  localparam int FRAME = N * R;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [15:0]  wr_data;
  logic [3:0]   wr_dp;
  logic [3:0]   wr_blank;

  logic         ack_h, ack_l;
  logic [3:0]   an_h, an_l;
  logic [6:0]   seg_h, seg_l;
  logic         dp_h, dp_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .CNT_BITS(C), .ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_blank(wr_blank), .wr_ack(ack_h), .an(an_h), .seg(seg_h), .dp(dp_h)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .CNT_BITS(C), .ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_blank(wr_blank), .wr_ack(ack_l), .an(an_l), .seg(seg_l), .dp(dp_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         t = 0;
  int         m_pos, m_dig;
  logic       m_valid = 1'b0;
  logic [15:0] m_sh_data, m_di_data;
  logic [3:0]  m_sh_dp, m_di_dp, m_sh_bl, m_di_bl;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ack;

  // t counts clock edges since reset; position in slot and digit follow by division.
  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      t = 0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_bl = '0;
      m_di_data = '0; m_di_dp = '0; m_di_bl = '0;
      e_an = '0; e_seg = '0; e_dp = 1'b0; e_ack = 1'b0;
    end else begin
      m_pos = t % R;
      m_dig = (t / R) % N;
      e_an = '0; e_seg = '0; e_dp = 1'b0;
      if (m_pos >= B) begin
        e_an = 4'(1 << m_dig);
        if (!m_di_bl[m_dig]) begin
          e_seg = seg_tab[m_di_data[m_dig*4 +: 4]];
          e_dp  = m_di_dp[m_dig];
        end
      end
      e_ack = wr_en;
      if (t % FRAME == FRAME - 1) begin
        m_di_data = m_sh_data; m_di_dp = m_sh_dp; m_di_bl = m_sh_bl;
      end
      if (wr_en) begin
        m_sh_data = wr_data; m_sh_dp = wr_dp; m_sh_bl = wr_blank;
      end
      t++;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("an_h",  32'(an_h),  32'(e_an));
      check("seg_h", 32'(seg_h), 32'(e_seg));
      check("dp_h",  32'(dp_h),  32'(e_dp));
      check("ack_h", 32'(ack_h), 32'(e_ack));
      check("an_l",  32'(an_l),  32'(4'(~e_an)));
      check("seg_l", 32'(seg_l), 32'(7'(~e_seg)));
      check("dp_l",  32'(dp_l),  32'(1'(~e_dp)));
      check("ack_l", 32'(ack_l), 32'(e_ack));
      check("an_onehot", 32'($countones(an_h) <= 1), 32'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_write(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl);
    wr_data = d; wr_dp = p; wr_blank = bl; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_ack_pulse", 32'(ack_h), 32'd1);
    @(negedge clk);
    check("wr_ack_single", 32'(ack_h), 32'd0);
  endtask

  task automatic wait_digit(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (an_h == 4'(1 << d)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic sample_digit(input int d, input logic [6:0] es, input logic ed);
    bit ok;
    wait_digit(d, ok);
    if (!ok) begin
      check("digit_timeout", 32'd0, 32'd1);
    end else begin
      check($sformatf("digit%0d_seg", d), 32'(seg_h), 32'(es));
      check($sformatf("digit%0d_dp", d),  32'(dp_h),  32'(ed));
    end
  endtask

  task automatic wait_boundary_cycle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (t % FRAME == FRAME - 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dp = '0; wr_blank = '0;

    // Reset held for three edges.
    repeat (3) begin
      @(negedge clk);
      check("rst_an_h",  32'(an_h),  32'h0);
      check("rst_seg_h", 32'(seg_h), 32'h0);
      check("rst_ack_h", 32'(ack_h), 32'h0);
      check("rst_an_l",  32'(an_l),  32'hF);
      check("rst_seg_l", 32'(seg_l), 32'h7F);
    end
    reset = 1'b0;

    // First enable appears on the third edge after release, showing digit 0 of 0000.
    @(negedge clk); check("rel1_an", 32'(an_h), 32'h0);
    @(negedge clk); check("rel2_an", 32'(an_h), 32'h0);
    @(negedge clk); check("rel3_an", 32'(an_h), 32'h1);
    check("rel3_seg", 32'(seg_h), 32'h3F);
    check("rel3_an_l", 32'(an_l), 32'hE);

    // 1234 with decimal point on digit 2; visible from the next frame.
    do_write(16'h1234, 4'b0100, 4'b0000);
    wait_digit(3, ok);
    check("wait_frame0", 32'(ok), 32'd1);
    sample_digit(0, 7'h66, 1'b0);
    sample_digit(1, 7'h4F, 1'b0);
    sample_digit(2, 7'h5B, 1'b1);
    sample_digit(3, 7'h06, 1'b0);

    // ABCD mid-frame: rest of this frame keeps 1234, next frame shows D,C,b,A.
    sample_digit(0, 7'h66, 1'b0);
    do_write(16'hABCD, 4'b0000, 4'b0000);
    sample_digit(1, 7'h4F, 1'b0);
    sample_digit(2, 7'h5B, 1'b1);
    sample_digit(3, 7'h06, 1'b0);
    sample_digit(0, 7'h5E, 1'b0);
    sample_digit(1, 7'h39, 1'b0);
    sample_digit(2, 7'h7C, 1'b0);
    sample_digit(3, 7'h77, 1'b0);

    // 5678 mid-frame, then 0F0F exactly on the boundary edge: 5678 for a frame, then 0F0F.
    do_write(16'h5678, 4'b0000, 4'b0000);
    wait_boundary_cycle(ok);
    check("wait_boundary", 32'(ok), 32'd1);
    do_write(16'h0F0F, 4'b0000, 4'b0000);
    sample_digit(0, 7'h7F, 1'b0);
    sample_digit(1, 7'h07, 1'b0);
    sample_digit(2, 7'h7D, 1'b0);
    sample_digit(3, 7'h6D, 1'b0);
    sample_digit(0, 7'h71, 1'b0);
    sample_digit(1, 7'h3F, 1'b0);
    sample_digit(2, 7'h71, 1'b0);
    sample_digit(3, 7'h3F, 1'b0);

    // 8888 with digits 1 and 3 forced dark; blanking also suppresses their dp.
    do_write(16'h8888, 4'b1111, 4'b1010);
    sample_digit(0, 7'h7F, 1'b1);
    sample_digit(1, 7'h00, 1'b0);
    sample_digit(2, 7'h7F, 1'b1);
    sample_digit(3, 7'h00, 1'b0);

    // Mid-frame reset with a pending write: the pending shadow is discarded.
    do_write(16'h4444, 4'b0000, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_an_h",  32'(an_h),  32'h0);
    check("mrst_an_l",  32'(an_l),  32'hF);
    check("mrst_seg_l", 32'(seg_l), 32'h7F);
    reset = 1'b0;
    sample_digit(0, 7'h3F, 1'b0);
    wait_digit(3, ok);
    check("wait_post_reset", 32'(ok), 32'd1);
    sample_digit(0, 7'h3F, 1'b0);
    sample_digit(1, 7'h3F, 1'b0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
